// File: rtl/rr_arb_pkg.sv
// Shared types and sizing helpers for the round-robin mux-select arbiter.
// Optional burst mode is enabled by defining RR_BURST_EN.
package rr_arb_pkg;

    localparam int unsigned N_IN_DEF = 4;
`ifdef RR_BURST_EN
    localparam int unsigned MAX_BURST_DEF = 4;
`endif

    typedef enum logic {
        IDLE  = 1'b0,
        GRANT = 1'b1
    } state_t;

    // Select width for n requesters; never narrower than one bit.
    function automatic int unsigned sel_w(input int unsigned n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/rr_prio_pick.sv
// Rotating-priority find-first: returns the first set request at or above ptr,
// wrapping past the top index back to zero.
module rr_prio_pick
    import rr_arb_pkg::*;
#(
    parameter  int unsigned N_IN  = N_IN_DEF,
    localparam int unsigned SEL_W = sel_w(N_IN)
) (
    input  logic [N_IN-1:0]  req,
    input  logic [SEL_W-1:0] ptr,
    output logic [SEL_W-1:0] idx,
    output logic             any
);

    logic             found;
    logic [SEL_W-1:0] cand;

    always_comb begin
        idx   = '0;
        found = 1'b0;
        cand  = '0;
        for (int unsigned i = 0; i < N_IN; i++) begin
            cand = ptr + SEL_W'(i);
            if (!found && req[cand]) begin
                idx   = cand;
                found = 1'b1;
            end
        end
    end

    assign any = |req;

endmodule

// File: rtl/rr_sel_arbiter.sv
// Round-robin arbiter driving the select of a 4:1 mux; holds sel until the
// consumer accepts the word. Define RR_BURST_EN for up to MAX_BURST beats per grant.
module rr_sel_arbiter
    import rr_arb_pkg::*;
#(
    parameter  int unsigned N_IN      = N_IN_DEF,
`ifdef RR_BURST_EN
    parameter  int unsigned MAX_BURST = MAX_BURST_DEF,
`endif
    localparam int unsigned SEL_W     = sel_w(N_IN)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [N_IN-1:0]  req,
    input  logic             out_ready,
    output logic [SEL_W-1:0] sel,
    output logic             sel_valid,
    output logic [N_IN-1:0]  grant,
    output logic             done
);

    state_t           state, state_d;
    logic [SEL_W-1:0] ptr, ptr_d;
    logic [SEL_W-1:0] sel_d, sel_inc, pick_ptr, pick_idx;
    logic             valid_d, done_d, pick_any, rotate;
    logic [N_IN-1:0]  grant_d;

`ifdef RR_BURST_EN
    localparam int unsigned BURST_W = $clog2(MAX_BURST + 1);
    logic [BURST_W-1:0] burst_cnt, burst_d;
`endif

    assign sel_inc = sel + SEL_W'(1);

    // While granted, the next candidate search starts just past the served input.
    assign pick_ptr = (state == GRANT) ? sel_inc : ptr;

    rr_prio_pick #(.N_IN(N_IN)) u_pick (
        .req (req),
        .ptr (pick_ptr),
        .idx (pick_idx),
        .any (pick_any)
    );

    always_comb begin
        state_d = state;
        ptr_d   = ptr;
        sel_d   = sel;
        valid_d = sel_valid;
        done_d  = 1'b0;
        rotate  = 1'b0;
`ifdef RR_BURST_EN
        burst_d = burst_cnt;
`endif
        case (state)
            IDLE: begin
`ifdef RR_BURST_EN
                burst_d = '0;
`endif
                if (pick_any) begin
                    sel_d   = pick_idx;
                    valid_d = 1'b1;
                    state_d = GRANT;
                end
            end
            GRANT: begin
                if (out_ready) begin
                    done_d = 1'b1;
`ifdef RR_BURST_EN
                    if (req[sel] && (burst_cnt < BURST_W'(MAX_BURST - 1))) begin
                        burst_d = burst_cnt + BURST_W'(1);
                    end else begin
                        burst_d = '0;
                        rotate  = 1'b1;
                    end
`else
                    rotate = 1'b1;
`endif
                end else if (!req[sel]) begin
                    // Requester withdrew before being served: drop the grant, keep ptr.
                    valid_d = 1'b0;
                    state_d = IDLE;
`ifdef RR_BURST_EN
                    burst_d = '0;
`endif
                end
            end
            default: state_d = IDLE;
        endcase

        if (rotate) begin
            ptr_d = sel_inc;
            if (pick_any) begin
                sel_d = pick_idx;
            end else begin
                valid_d = 1'b0;
                state_d = IDLE;
            end
        end

        grant_d = valid_d ? (N_IN'(1) << sel_d) : '0;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            ptr       <= '0;
            sel       <= '0;
            sel_valid <= 1'b0;
            grant     <= '0;
            done      <= 1'b0;
`ifdef RR_BURST_EN
            burst_cnt <= '0;
`endif
        end else begin
            state     <= state_d;
            ptr       <= ptr_d;
            sel       <= sel_d;
            sel_valid <= valid_d;
            grant     <= grant_d;
            done      <= done_d;
`ifdef RR_BURST_EN
            burst_cnt <= burst_d;
`endif
        end
    end

endmodule

// File: tb/tb_rr_sel_arbiter.sv
// Self-checking bench for rr_sel_arbiter: directed scenarios plus random traffic
// checked every cycle against a behavioural round-robin model.
module tb_rr_sel_arbiter;

    localparam int N    = 4;
    localparam int MAXB = 4;
`ifdef RR_BURST_EN
    localparam bit BURST = 1'b1;
`else
    localparam bit BURST = 1'b0;
`endif

    logic       clk = 1'b0;
    logic       rst_n = 1'b1;
    logic [3:0] req = 4'h0;
    logic       out_ready = 1'b0;
    logic [1:0] sel;
    logic       sel_valid;
    logic [3:0] grant;
    logic       done;

    int tests = 0;
    int fails = 0;
    bit cmp_en = 1'b0;

    rr_sel_arbiter dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .req       (req),
        .out_ready (out_ready),
        .sel       (sel),
        .sel_valid (sel_valid),
        .grant     (grant),
        .done      (done)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input int act, input int exp);
        tests++;
        if (act != exp) begin
            fails++;
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Behavioural model: plain integers, spec rules applied once per clock.
    int m_ptr = 0, m_sel = 0, m_burst = 0;
    bit m_valid = 1'b0, m_done = 1'b0, m_xfer;

    function automatic int first_from(input logic [3:0] r, input int from);
        for (int k = 0; k < N; k++) begin
            int idx;
            idx = (from + k) % N;
            if (r[idx]) return idx;
        end
        return 0;
    endfunction

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_ptr = 0; m_sel = 0; m_burst = 0; m_valid = 1'b0; m_done = 1'b0;
        end else begin
            m_xfer = m_valid && out_ready;
            m_done = m_xfer;
            if (!m_valid) begin
                m_burst = 0;
                if (req != 4'h0) begin
                    m_sel   = first_from(req, m_ptr);
                    m_valid = 1'b1;
                end
            end else if (m_xfer) begin
                if (BURST && req[m_sel] && (m_burst < MAXB - 1)) begin
                    m_burst = m_burst + 1;
                end else begin
                    m_burst = 0;
                    m_ptr   = (m_sel + 1) % N;
                    if (req != 4'h0) m_sel = first_from(req, m_ptr);
                    else m_valid = 1'b0;
                end
            end else if (!req[m_sel]) begin
                m_valid = 1'b0;
                m_burst = 0;
            end
        end
    end

    // Every-cycle comparison against the model.
    always @(negedge clk) begin
        if (cmp_en) begin
            chk("sel", int'(sel), m_sel);
            chk("sel_valid", int'(sel_valid), int'(m_valid));
            chk("grant", int'(grant), m_valid ? (1 << m_sel) : 0);
            chk("done", int'(done), int'(m_done));
        end
    end

    // Literal expectations, applied to both the DUT and the model.
    task automatic lit(input string name, input int e_sel, input int e_valid, input int e_done);
        chk({name, "_sel"}, int'(sel), e_sel);
        chk({name, "_valid"}, int'(sel_valid), e_valid);
        chk({name, "_done"}, int'(done), e_done);
        chk({name, "_grant"}, int'(grant), (e_valid != 0) ? (1 << e_sel) : 0);
        chk({name, "_model_sel"}, m_sel, e_sel);
        chk({name, "_model_valid"}, int'(m_valid), e_valid);
    endtask

    int t2_nb[4] = '{1, 2, 3, 0};
    int t2_b[4]  = '{0, 0, 0, 1};
    int t6_nb[9] = '{0, 3, 0, 3, 0, 3, 0, 3, 0};
    int t6_b[9]  = '{0, 0, 0, 0, 3, 3, 3, 3, 0};

    initial begin
        req = 4'hF;
        out_ready = 1'b0;
        #1 rst_n = 1'b0;
        cmp_en = 1'b1;
        repeat (2) @(negedge clk);
        lit("reset", 0, 0, 0);
        rst_n = 1'b1;

        // 1: first grant one edge after release
        @(negedge clk);
        lit("t1_first", 0, 1, 0);

        // 2: all requesting, consumer always ready
        out_ready = 1'b1;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            lit("t2_rot", BURST ? t2_b[i] : t2_nb[i], 1, 1);
        end
        req = 4'h0;
        @(negedge clk);
        lit("t2_drain", BURST ? 1 : 0, 0, 1);

        // 3: held select under backpressure
        req = 4'b0100;
        out_ready = 1'b0;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            lit("t3_hold", 2, 1, 0);
        end
        out_ready = 1'b1;
        req = 4'h0;
        @(negedge clk);
        lit("t3_xfer", 2, 0, 1);

        // 4: withdrawal leaves ptr unchanged
        req = 4'b0001;
        out_ready = 1'b0;
        @(negedge clk);
        lit("t4_prep", 0, 1, 0);
        req = 4'h0;
        out_ready = 1'b1;
        @(negedge clk);
        lit("t4_prep_x", 0, 0, 1);
        req = 4'b0010;
        out_ready = 1'b0;
        @(negedge clk);
        lit("t4_grant", 1, 1, 0);
        req = 4'h0;
        @(negedge clk);
        lit("t4_withdraw", 1, 0, 0);
        req = 4'b0011;
        @(negedge clk);
        lit("t4_ptr_kept", 1, 1, 0);

        // 5: asynchronous reset mid-grant
        req = 4'h0;
        out_ready = 1'b1;
        @(negedge clk);
        lit("t5_prep_x", 1, 0, 1);
        req = 4'b1000;
        out_ready = 1'b0;
        @(negedge clk);
        lit("t5_grant", 3, 1, 0);
        #2 rst_n = 1'b0;
        #1 lit("t5_async", 0, 0, 0);
        req = 4'b1001;
        out_ready = 1'b1;
        @(negedge clk);
        rst_n = 1'b1;

        // 6: two requesters, consumer always ready
        for (int i = 0; i < 9; i++) begin
            @(negedge clk);
            lit("t6_seq", BURST ? t6_b[i] : t6_nb[i], 1, (i > 0) ? 1 : 0);
        end

        // Random traffic with occasional asynchronous resets
        req = 4'h0;
        out_ready = 1'b0;
        repeat (3000) begin
            @(negedge clk);
            if ($urandom_range(3) == 0) req = 4'($urandom);
            out_ready = ($urandom_range(2) != 0);
            if ($urandom_range(199) == 0) begin
                #2 rst_n = 1'b0;
                @(negedge clk);
                rst_n = 1'b1;
            end
        end

        @(negedge clk);
        cmp_en = 1'b0;
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
